// File: rtl/mbl_msg_pkg.sv
// Shared widths, helpers and FSM state encoding for the MBL message initiator.
package mbl_msg_pkg;

  localparam int unsigned MBL_NUM_TAGS = 4;

  function automatic int unsigned mbl_tag_w(input int unsigned num_tags);
    return (num_tags > 1) ? $clog2(num_tags) : 1;
  endfunction

  function automatic int unsigned mbl_cnt_w(input int unsigned num_tags);
    return $clog2(num_tags) + 1;
  endfunction

  localparam int unsigned MBL_TAG_W = mbl_tag_w(MBL_NUM_TAGS);
  localparam int unsigned MBL_CNT_W = mbl_cnt_w(MBL_NUM_TAGS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/autoinst_mplist_mbl_if.sv
// Tagged message channel; the request side uses addr, the response side data/err.
interface autoinst_mplist_mbl_if
  import mbl_msg_pkg::*;
#(
  parameter int unsigned TAG_W  = MBL_TAG_W,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [TAG_W-1:0]  tag;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              err;

  modport master (output valid, output tag, output addr, input ready);
  modport slave  (input valid, input tag, input data, input err, output ready);
endinterface

// File: rtl/mbl_tag_alloc.sv
// Free-tag bitmap with lowest-free and lowest-used priority encoders.
module mbl_tag_alloc
  import mbl_msg_pkg::*;
#(
  parameter int unsigned NUM_TAGS = MBL_NUM_TAGS,
  parameter int unsigned TAG_W    = MBL_TAG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic                free_en,
  input  logic [TAG_W-1:0]    free_tag,
  output logic [NUM_TAGS-1:0] used_map,
  output logic                any_free_c,
  output logic [TAG_W-1:0]    low_free_c,
  output logic                any_used_c,
  output logic [TAG_W-1:0]    low_used_c
);

  logic [NUM_TAGS-1:0] used_map_d;

  // Scan high to low so the lowest index wins.
  always_comb begin
    any_free_c = 1'b0;
    low_free_c = '0;
    any_used_c = 1'b0;
    low_used_c = '0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!used_map[i]) begin
        any_free_c = 1'b1;
        low_free_c = TAG_W'(i);
      end else begin
        any_used_c = 1'b1;
        low_used_c = TAG_W'(i);
      end
    end
  end

  // Free and allocate always target different tags, so both apply together.
  always_comb begin
    used_map_d = used_map;
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      if (free_en && (free_tag == TAG_W'(i))) used_map_d[i] = 1'b0;
      if (alloc_en && any_free_c && (low_free_c == TAG_W'(i))) used_map_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) used_map <= '0;
    else       used_map <= used_map_d;
  end

endmodule

// File: rtl/mbl_msg_initiator.sv
// Tagged request initiator: allocates tags for local commands, matches responses
// to completions, and flushes all outstanding tags after a response timeout.
module mbl_msg_initiator
  import mbl_msg_pkg::*;
#(
  parameter int unsigned NUM_TAGS    = MBL_NUM_TAGS,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  autoinst_mplist_mbl_if.master            msg_req_if,
  autoinst_mplist_mbl_if.slave             msg_resp_if,
  input  logic                             msg_busy,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  output logic                             cpl_valid,
  output logic [mbl_tag_w(NUM_TAGS)-1:0]   cpl_tag,
  output logic [DATA_W-1:0]                cpl_data,
  output logic                             cpl_err,
  output logic [mbl_cnt_w(NUM_TAGS)-1:0]   outstanding,
  output logic                             stray_err
);

  localparam int unsigned TAG_W = mbl_tag_w(NUM_TAGS);
  localparam int unsigned CNT_W = mbl_cnt_w(NUM_TAGS);
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                resp_ready_q;
  logic                req_valid_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic [ADDR_W-1:0]   req_addr_q;

  logic [NUM_TAGS-1:0] used_map;
  logic                any_free_c, any_used_c;
  logic [TAG_W-1:0]    low_free_c, low_used_c;
  logic [TAG_W-1:0]    resp_tag;
  logic                resp_alloc;
  logic                in_flush, resp_acc, resp_hit, resp_stray, flush_fire;
  logic                alloc_en, free_en, tmo_hit;
  logic [TAG_W-1:0]    free_tag;

  mbl_tag_alloc #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_tag_alloc (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .free_en    (free_en),
    .free_tag   (free_tag),
    .used_map   (used_map),
    .any_free_c (any_free_c),
    .low_free_c (low_free_c),
    .any_used_c (any_used_c),
    .low_used_c (low_used_c)
  );

  assign resp_tag = msg_resp_if.tag;

  always_comb begin
    resp_alloc = 1'b0;
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      if (used_map[i] && (resp_tag == TAG_W'(i))) resp_alloc = 1'b1;
    end
  end

  // Responses seen during FLUSH are swallowed: no completion, no stray flag.
  assign in_flush   = (state_q == ST_FLUSH);
  assign resp_acc   = msg_resp_if.valid && resp_ready_q;
  assign resp_hit   = resp_acc && !in_flush && resp_alloc;
  assign resp_stray = resp_acc && !in_flush && !resp_alloc;
  assign flush_fire = in_flush && any_used_c;

  // resp_ready_q doubles as the out-of-reset qualifier for cmd_ready.
  assign cmd_ready = resp_ready_q && !in_flush && any_free_c && !msg_busy && !req_valid_q;
  assign alloc_en  = cmd_valid && cmd_ready;
  assign free_en   = resp_hit || flush_fire;
  assign free_tag  = flush_fire ? low_used_c : resp_tag;
  assign tmo_hit   = !in_flush && (cnt_q != '0) && !resp_acc && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(alloc_en) - CNT_W'(free_en);
    tmo_d   = tmo_q + TMO_W'(1);
    if ((cnt_q == '0) || resp_acc || in_flush) tmo_d = '0;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (tmo_hit)             state_d = ST_FLUSH;
        else if (cnt_d == '0)    state_d = ST_IDLE;
        else                     state_d = ST_ACTIVE;
      end
      ST_FLUSH: begin
        if (cnt_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      tmo_q        <= '0;
      resp_ready_q <= 1'b0;
      req_valid_q  <= 1'b0;
      req_tag_q    <= '0;
      req_addr_q   <= '0;
      cpl_valid    <= 1'b0;
      cpl_tag      <= '0;
      cpl_data     <= '0;
      cpl_err      <= 1'b0;
      stray_err    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      resp_ready_q <= 1'b1;
      if (alloc_en) begin
        req_valid_q <= 1'b1;
        req_tag_q   <= low_free_c;
        req_addr_q  <= cmd_addr;
      end else if (req_valid_q && msg_req_if.ready) begin
        req_valid_q <= 1'b0;
      end
      cpl_valid <= free_en;
      if (free_en) begin
        cpl_tag  <= free_tag;
        cpl_data <= flush_fire ? '0 : msg_resp_if.data;
        cpl_err  <= flush_fire || msg_resp_if.err;
      end
      if (resp_stray) stray_err <= 1'b1;
    end
  end

  assign msg_req_if.valid  = req_valid_q;
  assign msg_req_if.tag    = req_tag_q;
  assign msg_req_if.addr   = req_addr_q;
  assign msg_resp_if.ready = resp_ready_q;
  assign outstanding       = cnt_q;

endmodule

// File: tb/tb_mbl_msg_initiator.sv
// Directed bench for mbl_msg_initiator; inputs change and outputs are sampled on the falling edge.
module tb_mbl_msg_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        msg_busy;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cpl_valid;
  logic [1:0]  cpl_tag;
  logic [31:0] cpl_data;
  logic        cpl_err;
  logic [2:0]  outstanding;
  logic        stray_err;

  int cmps = 0;
  int errs = 0;
  int cpl_cnt = 0;

  autoinst_mplist_mbl_if #(.TAG_W(2), .ADDR_W(32), .DATA_W(32)) req_if ();
  autoinst_mplist_mbl_if #(.TAG_W(2), .ADDR_W(32), .DATA_W(32)) resp_if ();

  assign req_if.data  = '0;
  assign req_if.err   = 1'b0;
  assign resp_if.addr = '0;

  mbl_msg_initiator #(
    .NUM_TAGS    (4),
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .msg_req_if  (req_if),
    .msg_resp_if (resp_if),
    .msg_busy    (msg_busy),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cpl_valid   (cpl_valid),
    .cpl_tag     (cpl_tag),
    .cpl_data    (cpl_data),
    .cpl_err     (cpl_err),
    .outstanding (outstanding),
    .stray_err   (stray_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cpl_valid === 1'b1) cpl_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [31:0] a);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      cmps++; errs++;
      $display("FAIL send_cmd_wait: cmd_ready=%b after %0d cycles, need 1", cmd_ready, n);
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic accept_req();
    req_if.ready = 1'b1;
    tick();
    req_if.ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    cmps++; if ({req_if.valid, req_if.tag, req_if.addr} !== 35'd0) begin errs++;
      $display("FAIL rst_req: got %h need 0", {req_if.valid, req_if.tag, req_if.addr}); end
    cmps++; if (resp_if.ready !== 1'b0) begin errs++;
      $display("FAIL rst_resp_ready: got %b need 0", resp_if.ready); end
    cmps++; if (cmd_ready !== 1'b0) begin errs++;
      $display("FAIL rst_cmd_ready: got %b need 0", cmd_ready); end
    cmps++; if ({cpl_valid, cpl_tag, cpl_data, cpl_err} !== 36'd0) begin errs++;
      $display("FAIL rst_cpl: got %h need 0", {cpl_valid, cpl_tag, cpl_data, cpl_err}); end
    cmps++; if ({outstanding, stray_err} !== 4'd0) begin errs++;
      $display("FAIL rst_cnt_stray: got %h need 0", {outstanding, stray_err}); end
    reset = 1'b0;
    tick();
    cmps++; if ({resp_if.ready, cmd_ready} !== 2'b11) begin errs++;
      $display("FAIL rst_release: ready/cmd_ready got %b need 11", {resp_if.ready, cmd_ready}); end
  endtask

  task automatic test_single();
    int base;
    send_cmd(32'h1000);
    cmps++; if ({req_if.valid, req_if.tag, req_if.addr} !== {1'b1, 2'd0, 32'h1000}) begin errs++;
      $display("FAIL single_req: got %h need %h", {req_if.valid, req_if.tag, req_if.addr}, {1'b1, 2'd0, 32'h1000}); end
    cmps++; if (outstanding !== 3'd1) begin errs++;
      $display("FAIL single_outst: got %0d need 1", outstanding); end
    accept_req();
    cmps++; if (req_if.valid !== 1'b0) begin errs++;
      $display("FAIL single_req_drop: got %b need 0", req_if.valid); end
    base = cpl_cnt;
    tick(); tick();
    resp_if.valid = 1'b1; resp_if.tag = 2'd0; resp_if.data = 32'hDEADBEEF; resp_if.err = 1'b0;
    tick();
    resp_if.valid = 1'b0;
    cmps++; if ({cpl_valid, cpl_tag, cpl_data, cpl_err} !== {1'b1, 2'd0, 32'hDEADBEEF, 1'b0}) begin errs++;
      $display("FAIL single_cpl: got %h need %h", {cpl_valid, cpl_tag, cpl_data, cpl_err}, {1'b1, 2'd0, 32'hDEADBEEF, 1'b0}); end
    cmps++; if (outstanding !== 3'd0) begin errs++;
      $display("FAIL single_outst_end: got %0d need 0", outstanding); end
    tick(); tick();
    cmps++; if (cpl_cnt - base !== 1) begin errs++;
      $display("FAIL single_cpl_count: got %0d need 1", cpl_cnt - base); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  order [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    logic [31:0] exp_data;
    for (int i = 0; i < 4; i++) begin
      send_cmd(32'h2000 + 32'(i) * 32'h10);
      cmps++; if ({req_if.valid, req_if.tag, req_if.addr} !== {1'b1, 2'(i), 32'h2000 + 32'(i) * 32'h10}) begin errs++;
        $display("FAIL b2b_req%0d: got %h", i, {req_if.valid, req_if.tag, req_if.addr}); end
      accept_req();
    end
    cmd_valid = 1'b1; cmd_addr = 32'h2040;
    tick(); tick();
    cmps++; if ({cmd_ready, outstanding, req_if.valid} !== {1'b0, 3'd4, 1'b0}) begin errs++;
      $display("FAIL b2b_full: ready/outst/req got %b need 0_100_0", {cmd_ready, outstanding, req_if.valid}); end
    for (int k = 0; k < 4; k++) begin
      exp_data = 32'hA5A50000 | 32'(order[k]);
      resp_if.valid = 1'b1; resp_if.tag = order[k]; resp_if.data = exp_data;
      resp_if.err = (order[k] == 2'd3);
      tick();
      cmps++; if ({cpl_valid, cpl_tag, cpl_data, cpl_err} !== {1'b1, order[k], exp_data, order[k] == 2'd3}) begin errs++;
        $display("FAIL b2b_cpl%0d: got %h need %h", k, {cpl_valid, cpl_tag, cpl_data, cpl_err}, {1'b1, order[k], exp_data, order[k] == 2'd3}); end
      if (k == 0) begin
        cmps++; if (cmd_ready !== 1'b1) begin errs++;
          $display("FAIL b2b_fifth_ready: got %b need 1", cmd_ready); end
      end
      if (k == 1) begin
        cmps++; if ({req_if.valid, req_if.tag, req_if.addr, outstanding} !== {1'b1, 2'd2, 32'h2040, 3'd3}) begin errs++;
          $display("FAIL b2b_fifth_req: got %h", {req_if.valid, req_if.tag, req_if.addr, outstanding}); end
        cmd_valid = 1'b0;
      end
    end
    resp_if.valid = 1'b0;
    tick();
    cmps++; if ({cpl_valid, outstanding} !== {1'b0, 3'd1}) begin errs++;
      $display("FAIL b2b_after: cpl_valid/outst got %b need 0_001", {cpl_valid, outstanding}); end
    accept_req();
    resp_if.valid = 1'b1; resp_if.tag = 2'd2; resp_if.data = 32'h2222; resp_if.err = 1'b0;
    tick();
    resp_if.valid = 1'b0;
    cmps++; if ({cpl_valid, cpl_tag, cpl_data, cpl_err, outstanding} !== {1'b1, 2'd2, 32'h2222, 1'b0, 3'd0}) begin errs++;
      $display("FAIL b2b_fifth_cpl: got %h", {cpl_valid, cpl_tag, cpl_data, cpl_err, outstanding}); end
  endtask

  task automatic test_req_hold();
    send_cmd(32'h3000);
    for (int c = 0; c < 6; c++) begin
      cmps++; if ({req_if.valid, req_if.tag, req_if.addr, cmd_ready} !== {1'b1, 2'd0, 32'h3000, 1'b0}) begin errs++;
        $display("FAIL hold_c%0d: valid/tag/addr/cmd_ready got %h", c, {req_if.valid, req_if.tag, req_if.addr, cmd_ready}); end
      if (c < 5) tick();
    end
    accept_req();
    cmps++; if ({req_if.valid, cmd_ready} !== 2'b01) begin errs++;
      $display("FAIL hold_release: valid/cmd_ready got %b need 01", {req_if.valid, cmd_ready}); end
    msg_busy = 1'b1;
    #1;
    cmps++; if (cmd_ready !== 1'b0) begin errs++;
      $display("FAIL busy_block: got %b need 0", cmd_ready); end
    msg_busy = 1'b0;
    #1;
    cmps++; if (cmd_ready !== 1'b1) begin errs++;
      $display("FAIL busy_clear: got %b need 1", cmd_ready); end
    resp_if.valid = 1'b1; resp_if.tag = 2'd0; resp_if.data = 32'h3333; resp_if.err = 1'b0;
    tick();
    resp_if.valid = 1'b0;
    cmps++; if ({cpl_valid, cpl_tag, cpl_data, outstanding} !== {1'b1, 2'd0, 32'h3333, 3'd0}) begin errs++;
      $display("FAIL hold_cpl: got %h", {cpl_valid, cpl_tag, cpl_data, outstanding}); end
  endtask

  task automatic test_stray();
    send_cmd(32'h4000);
    accept_req();
    resp_if.valid = 1'b1; resp_if.tag = 2'd3; resp_if.data = 32'h4444; resp_if.err = 1'b0;
    tick();
    resp_if.valid = 1'b0;
    cmps++; if ({stray_err, cpl_valid, outstanding} !== {1'b1, 1'b0, 3'd1}) begin errs++;
      $display("FAIL stray: stray/cpl_valid/outst got %b need 1_0_001", {stray_err, cpl_valid, outstanding}); end
    resp_if.valid = 1'b1; resp_if.tag = 2'd0; resp_if.data = 32'h40000001;
    tick();
    resp_if.valid = 1'b0;
    cmps++; if ({cpl_valid, cpl_tag, cpl_data, outstanding, stray_err} !== {1'b1, 2'd0, 32'h40000001, 3'd0, 1'b1}) begin errs++;
      $display("FAIL stray_followup: got %h", {cpl_valid, cpl_tag, cpl_data, outstanding, stray_err}); end
  endtask

  task automatic test_reset_mid();
    int base;
    send_cmd(32'h5000);
    accept_req();
    send_cmd(32'h5010);
    cmps++; if ({req_if.tag, outstanding} !== {2'd1, 3'd2}) begin errs++;
      $display("FAIL rmid_setup: tag/outst got %b need 01_010", {req_if.tag, outstanding}); end
    accept_req();
    base = cpl_cnt;
    reset = 1'b1;
    #1;
    cmps++; if ({req_if.valid, req_if.tag, req_if.addr, resp_if.ready, cmd_ready} !== 37'd0) begin errs++;
      $display("FAIL rmid_req: got %h need 0", {req_if.valid, req_if.tag, req_if.addr, resp_if.ready, cmd_ready}); end
    cmps++; if ({cpl_valid, cpl_tag, cpl_data, cpl_err, outstanding, stray_err} !== 40'd0) begin errs++;
      $display("FAIL rmid_out: got %h need 0", {cpl_valid, cpl_tag, cpl_data, cpl_err, outstanding, stray_err}); end
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    cmps++; if (cpl_cnt !== base) begin errs++;
      $display("FAIL rmid_no_cpl: got %0d completions need 0", cpl_cnt - base); end
    send_cmd(32'h5020);
    cmps++; if ({req_if.valid, req_if.tag, req_if.addr, outstanding} !== {1'b1, 2'd0, 32'h5020, 3'd1}) begin errs++;
      $display("FAIL rmid_newtag: got %h", {req_if.valid, req_if.tag, req_if.addr, outstanding}); end
    accept_req();
    resp_if.valid = 1'b1; resp_if.tag = 2'd0; resp_if.data = 32'h5555; resp_if.err = 1'b0;
    tick();
    resp_if.valid = 1'b0;
    cmps++; if ({cpl_valid, cpl_tag, outstanding} !== {1'b1, 2'd0, 3'd0}) begin errs++;
      $display("FAIL rmid_cpl: got %b", {cpl_valid, cpl_tag, outstanding}); end
  endtask

  task automatic test_timeout();
    send_cmd(32'h6000);
    accept_req();
    send_cmd(32'h6010);
    cmps++; if ({req_if.tag, outstanding} !== {2'd1, 3'd2}) begin errs++;
      $display("FAIL tmo_setup: tag/outst got %b need 01_010", {req_if.tag, outstanding}); end
    accept_req();
    repeat (12) tick();
    cmps++; if ({cmd_ready, cpl_valid, outstanding} !== {1'b1, 1'b0, 3'd2}) begin errs++;
      $display("FAIL tmo_before: ready/cpl/outst got %b need 1_0_010", {cmd_ready, cpl_valid, outstanding}); end
    tick();
    cmps++; if ({cmd_ready, cpl_valid} !== 2'b00) begin errs++;
      $display("FAIL tmo_flush_entry: ready/cpl got %b need 00", {cmd_ready, cpl_valid}); end
    resp_if.valid = 1'b1; resp_if.tag = 2'd0; resp_if.data = 32'h55; resp_if.err = 1'b0;
    tick();
    cmps++; if ({cpl_valid, cpl_tag, cpl_data, cpl_err, outstanding} !== {1'b1, 2'd0, 32'd0, 1'b1, 3'd1}) begin errs++;
      $display("FAIL tmo_flush0: got %h", {cpl_valid, cpl_tag, cpl_data, cpl_err, outstanding}); end
    resp_if.tag = 2'd3;
    tick();
    resp_if.valid = 1'b0;
    cmps++; if ({cpl_valid, cpl_tag, cpl_data, cpl_err, outstanding} !== {1'b1, 2'd1, 32'd0, 1'b1, 3'd0}) begin errs++;
      $display("FAIL tmo_flush1: got %h", {cpl_valid, cpl_tag, cpl_data, cpl_err, outstanding}); end
    tick();
    cmps++; if ({cpl_valid, stray_err, cmd_ready} !== 3'b001) begin errs++;
      $display("FAIL tmo_idle: cpl/stray/ready got %b need 001", {cpl_valid, stray_err, cmd_ready}); end
  endtask

  initial begin
    reset         = 1'b1;
    msg_busy      = 1'b0;
    cmd_valid     = 1'b0;
    cmd_addr      = '0;
    req_if.ready  = 1'b0;
    resp_if.valid = 1'b0;
    resp_if.tag   = '0;
    resp_if.data  = '0;
    resp_if.err   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_req_hold();
    test_stray();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
